bus_arbiter: RTL and testbench

Two-master arbiter for the native picorv32 memory bus. It lets the CPU (master 0) and one auxiliary bus master (master 1: a DMA engine or self-test driver) share a single downstream bus. That bus feeds the address decoder and peripherals (memory, gpio, uartTx, prng, timer). Arbitration is round-robin with single-transaction grants. A per-transaction watchdog terminates any access that a hung or unmapped slave never completes.

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_watchdog.sv | 32 +++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter
// and the bus watchdog.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam int          WD_WIDTH         = 16;

endpackage

// File: rtl/bus_watchdog.sv
// Per-transaction watchdog: counts enabled cycles since the last clear
// and flags expiry once the count reaches TIMEOUT-1.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT - 1);

    logic [WD_WIDTH-1:0] count;

    // Holds at the limit so expiry stays asserted until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WD_WIDTH'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter letting the CPU and one auxiliary master share
// the native picorv32 memory bus, with a per-transaction watchdog.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [3:0]  m0_mem_wstrb,
    input  logic [31:0] m0_mem_wdata,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [3:0]  m1_mem_wstrb,
    input  logic [31:0] m1_mem_wdata,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [3:0]  s_mem_wstrb,
    output logic [31:0] s_mem_wdata,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   busy;
    logic   gnt_valid;
    logic   wd_expired;
    logic   wd_fire;

    assign busy = (state == BUSY0) || (state == BUSY1);

    assign gnt_valid = (state == BUSY0) ? m0_mem_valid :
                       (state == BUSY1) ? m1_mem_valid : 1'b0;

    // Slave completion on the expiry cycle beats the watchdog
    assign wd_fire = busy && gnt_valid && wd_expired && !s_mem_ready;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !s_mem_ready),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= wd_fire;
            // Only a tie moves the pointer; the loser of a tie wins the next one
            if (state == IDLE && m0_mem_valid && m1_mem_valid) begin
                last <= ~last;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_mem_valid && m1_mem_valid) begin
                    state_nxt = last ? BUSY0 : BUSY1;
                end else if (m0_mem_valid) begin
                    state_nxt = BUSY0;
                end else if (m1_mem_valid) begin
                    state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (!gnt_valid || s_mem_ready || wd_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant        = 2'b00;
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wstrb  = '0;
        s_mem_wdata  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        case (state)
            BUSY0: begin
                grant        = 2'b01;
                s_mem_valid  = m0_mem_valid && !wd_fire;
                s_mem_instr  = m0_mem_instr;
                s_mem_addr   = m0_mem_addr;
                s_mem_wstrb  = m0_mem_wstrb;
                s_mem_wdata  = m0_mem_wdata;
                m0_mem_ready = (s_mem_ready && m0_mem_valid) || wd_fire;
                m0_mem_rdata = wd_fire ? ERR_DATA : s_mem_rdata;
            end
            BUSY1: begin
                grant        = 2'b10;
                s_mem_valid  = m1_mem_valid && !wd_fire;
                s_mem_instr  = m1_mem_instr;
                s_mem_addr   = m1_mem_addr;
                s_mem_wstrb  = m1_mem_wstrb;
                s_mem_wdata  = m1_mem_wdata;
                m1_mem_ready = (s_mem_ready && m1_mem_valid) || wd_fire;
                m1_mem_rdata = wd_fire ? ERR_DATA : s_mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with TIMEOUT = 8.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic [3:0]  m0_mem_wstrb;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic [3:0]  m1_mem_wstrb;
    logic        s_mem_valid, s_mem_instr, s_mem_ready;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [3:0]  s_mem_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    logic        zw;
    logic        man_ready;
    logic [31:0] man_rdata;

    int errors = 0;
    int checks = 0;
    int te_pulses = 0;

    always #5 clk = ~clk;

    // Slave: zero-wait follows the registered grant, otherwise manual
    assign s_mem_ready = zw ? (grant != 2'b00) : man_ready;
    assign s_mem_rdata = man_rdata;

    always @(negedge clk) if (timeout_err === 1'b1) te_pulses++;

    bus_arbiter #(
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_mem_valid (m0_mem_valid),
        .m0_mem_instr (m0_mem_instr),
        .m0_mem_addr  (m0_mem_addr),
        .m0_mem_wstrb (m0_mem_wstrb),
        .m0_mem_wdata (m0_mem_wdata),
        .m0_mem_ready (m0_mem_ready),
        .m0_mem_rdata (m0_mem_rdata),
        .m1_mem_valid (m1_mem_valid),
        .m1_mem_instr (m1_mem_instr),
        .m1_mem_addr  (m1_mem_addr),
        .m1_mem_wstrb (m1_mem_wstrb),
        .m1_mem_wdata (m1_mem_wdata),
        .m1_mem_ready (m1_mem_ready),
        .m1_mem_rdata (m1_mem_rdata),
        .s_mem_valid  (s_mem_valid),
        .s_mem_instr  (s_mem_instr),
        .s_mem_addr   (s_mem_addr),
        .s_mem_wstrb  (s_mem_wstrb),
        .s_mem_wdata  (s_mem_wdata),
        .s_mem_ready  (s_mem_ready),
        .s_mem_rdata  (s_mem_rdata),
        .grant        (grant),
        .timeout_err  (timeout_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        m0_mem_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        checks++;
        if (s_mem_valid !== 1'b0) begin
            errors++; $display("FAIL reset_s_valid: got %b expected 0", s_mem_valid);
        end
        checks++;
        if ({m0_mem_ready, m1_mem_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b%b expected 00", m0_mem_ready, m1_mem_ready);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        end
        step;
        reset = 1'b0;
        m0_mem_valid = 1'b0;
        step;
    endtask

    task automatic test_single;
        m0_mem_valid = 1'b1;
        m0_mem_addr  = 32'h0000_0100;
        m0_mem_wstrb = 4'h0;
        @(negedge clk);
        checks++;
        if (s_mem_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency: s_valid got %b expected 0", s_mem_valid);
        end
        step;
        @(negedge clk);
        checks++;
        if ({s_mem_valid, grant, s_mem_addr} !== {1'b1, 2'b01, 32'h0000_0100}) begin
            errors++;
            $display("FAIL single_c1: valid=%b grant=%b addr=%h expected 1 01 00000100",
                     s_mem_valid, grant, s_mem_addr);
        end
        step;
        @(negedge clk);
        checks++;
        if (m0_mem_ready !== 1'b0) begin
            errors++; $display("FAIL single_c2_ready: got %b expected 0", m0_mem_ready);
        end
        step;
        man_ready = 1'b1;
        man_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({m0_mem_ready, m0_mem_rdata, m1_mem_ready} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL single_c3: m0_ready=%b rdata=%h m1_ready=%b expected 1 12345678 0",
                     m0_mem_ready, m0_mem_rdata, m1_mem_ready);
        end
        step;
        man_ready = 1'b0;
        m0_mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL single_idle: grant got %b expected 00", grant);
        end
        step;
    endtask

    task automatic test_tie;
        logic [1:0] exp_g [8];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
        zw = 1'b1;
        m0_mem_addr = 32'h0000_0200;
        m1_mem_addr = 32'h0000_0300;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 4) begin
                m0_mem_valid = 1'b1;
                m1_mem_valid = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (grant !== exp_g[i]) begin
                errors++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, grant, exp_g[i]);
            end
            step;
            if (grant == 2'b00 && exp_g[i] == 2'b01) m0_mem_valid = 1'b0;
            if (grant == 2'b00 && exp_g[i] == 2'b10) m1_mem_valid = 1'b0;
        end
        zw = 1'b0;
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
    endtask

    task automatic test_starvation;
        int g0 = 0;
        int g1 = 0;
        logic [1:0] exp;
        zw = 1'b1;
        m0_mem_valid = 1'b1;
        m1_mem_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp = (i % 2 == 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (grant !== exp) begin
                errors++; $display("FAIL starve_grant[%0d]: got %b expected %b", i, grant, exp);
            end
            if (grant == 2'b01) g0++;
            if (grant == 2'b10) g1++;
            step;
        end
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        zw = 1'b0;
        checks++;
        if (g0 != 10 || g1 != 10) begin
            errors++; $display("FAIL starve_counts: got m0=%0d m1=%0d expected 10 10", g0, g1);
        end
        step;
    endtask

    task automatic test_timeout;
        int base;
        for (int k = 0; k < 2; k++) begin
            base = te_pulses;
            man_ready = 1'b0;
            m1_mem_valid = 1'b1;
            m1_mem_addr  = 32'hFFFF_0070;
            m1_mem_wstrb = (k == 0) ? 4'hF : 4'h0;
            m1_mem_wdata = 32'hCAFE_F00D;
            @(negedge clk);
            step;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    checks++;
                    if ({s_mem_addr, s_mem_wstrb} !== {32'hFFFF_0070, m1_mem_wstrb}) begin
                        errors++;
                        $display("FAIL to_fwd[%0d]: addr=%h wstrb=%h expected ffff0070 %h",
                                 k, s_mem_addr, s_mem_wstrb, m1_mem_wstrb);
                    end
                end
                if (c < 8) begin
                    checks++;
                    if ({m1_mem_ready, s_mem_valid} !== 2'b01) begin
                        errors++;
                        $display("FAIL to_wait[%0d] c%0d: ready,valid got %b%b expected 01",
                                 k, c, m1_mem_ready, s_mem_valid);
                    end
                end else begin
                    checks++;
                    if ({m1_mem_ready, s_mem_valid, grant} !== 4'b1010) begin
                        errors++;
                        $display("FAIL to_expire[%0d]: ready,valid,grant got %b%b%b expected 1010",
                                 k, m1_mem_ready, s_mem_valid, grant);
                    end
                    if (k == 1) begin
                        checks++;
                        if (m1_mem_rdata !== 32'hDEAD_BEEF) begin
                            errors++;
                            $display("FAIL to_rdata: got %h expected deadbeef", m1_mem_rdata);
                        end
                    end
                end
                step;
            end
            m1_mem_valid = 1'b0;
            @(negedge clk);
            step;
            @(negedge clk);
            step;
            checks++;
            if (te_pulses - base != 1) begin
                errors++; $display("FAIL to_pulses[%0d]: got %0d expected 1", k, te_pulses - base);
            end
        end
    endtask

    task automatic test_expiry_ready;
        int base;
        base = te_pulses;
        man_ready = 1'b0;
        m0_mem_valid = 1'b1;
        m0_mem_addr  = 32'h0000_0400;
        m0_mem_wstrb = 4'h0;
        @(negedge clk);
        step;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                man_ready = 1'b1;
                man_rdata = 32'hA5A5_A5A5;
            end
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if ({m0_mem_ready, s_mem_valid, m0_mem_rdata} !== {2'b11, 32'hA5A5_A5A5}) begin
                    errors++;
                    $display("FAIL exp_ready: ready=%b valid=%b rdata=%h expected 1 1 a5a5a5a5",
                             m0_mem_ready, s_mem_valid, m0_mem_rdata);
                end
            end
            step;
        end
        man_ready = 1'b0;
        m0_mem_valid = 1'b0;
        @(negedge clk);
        step;
        @(negedge clk);
        step;
        checks++;
        if (te_pulses != base) begin
            errors++; $display("FAIL exp_no_err: pulses got %0d expected 0", te_pulses - base);
        end
    endtask

    task automatic test_reset_mid;
        man_ready = 1'b0;
        m0_mem_valid = 1'b1;
        m1_mem_valid = 1'b1;
        @(negedge clk);
        step;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rst_pre_grant: got %b expected 01", grant);
        end
        step;
        @(negedge clk);
        #1;
        man_ready = 1'b1;
        man_rdata = 32'h0BAD_0BAD;
        #1;
        checks++;
        if (m0_mem_ready !== 1'b1) begin
            errors++; $display("FAIL rst_pre_ready: got %b expected 1", m0_mem_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_mem_valid, grant, m0_mem_ready, timeout_err} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_async: valid=%b grant=%b ready=%b terr=%b expected all 0",
                     s_mem_valid, grant, m0_mem_ready, timeout_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL rst_idle: got %b expected 00", grant);
        end
        step;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rst_m0_first: got %b expected 01", grant);
        end
        step;
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_mem_ready, s_mem_valid} !== 2'b00) begin
            errors++;
            $display("FAIL drop_valid: ready,valid got %b%b expected 00", m0_mem_ready, s_mem_valid);
        end
        step;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL drop_idle: grant got %b expected 00", grant);
        end
        step;
    endtask

    initial begin
        reset = 1'b1;
        zw = 1'b0;
        man_ready = 1'b0;
        man_rdata = '0;
        m0_mem_valid = 1'b0; m0_mem_instr = 1'b0; m0_mem_addr = '0;
        m0_mem_wstrb = '0;   m0_mem_wdata = '0;
        m1_mem_valid = 1'b0; m1_mem_instr = 1'b0; m1_mem_addr = '0;
        m1_mem_wstrb = '0;   m1_mem_wdata = '0;
        test_reset;
        test_single;
        test_tie;
        test_starvation;
        test_timeout;
        test_expiry_ready;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
